// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register-index width, x0 index, sequencer states.
package riscv_pipe_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_HOLD  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares a producer destination against the ID-stage sources; x0 never matches.
module hazard_match
   import riscv_pipe_pkg::*;
(
   input  logic [REG_W-1:0] rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   output logic             match
);

   // A match needs a real destination and a source that is actually read.
   always_comb begin
      match = (rd != REG_ZERO) &&
              ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand stall sequencer with memory hold and event counters.
module hazard_stall_controller
   import riscv_pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_use_rs1,
   input  logic             if_id_use_rs2,
   input  logic             if_id_is_branch,
   input  logic             id_ex_memread,
   input  logic             id_ex_regwrite,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic             ex_mem_memread,
   input  logic [REG_W-1:0] ex_mem_rd,
   input  logic             branch_taken,
   input  logic             mem_hold,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   pipe_state_t state, state_nx, ret_state, ret_nx, eff_state;
   logic [1:0]  remain, remain_nx;
   logic        m_ex, m_mem;
   logic        hz_lb, hz_one;

   hazard_match u_match_ex (
      .rd(id_ex_rd), .rs1(if_id_rs1), .rs2(if_id_rs2),
      .use_rs1(if_id_use_rs1), .use_rs2(if_id_use_rs2), .match(m_ex)
   );

   hazard_match u_match_mem (
      .rd(ex_mem_rd), .rs1(if_id_rs1), .rs2(if_id_rs2),
      .use_rs1(if_id_use_rs1), .use_rs2(if_id_use_rs2), .match(m_mem)
   );

   // Hazard classes: load->branch needs two cycles, the others one.
   always_comb begin
      hz_lb  = if_id_is_branch && id_ex_memread && m_ex;
      hz_one = (!if_id_is_branch && id_ex_memread && m_ex) ||
               (if_id_is_branch && id_ex_regwrite && !id_ex_memread && m_ex) ||
               (if_id_is_branch && ex_mem_memread && m_mem);
      // HOLD is transparent: a released cycle behaves as the frozen state.
      eff_state = (state == ST_HOLD) ? ret_state : state;
   end

   // Next state and same-cycle pipeline controls.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pipe_hold    = 1'b0;
      state_nx     = state;
      ret_nx       = ret_state;
      remain_nx    = remain;
      if (reset) begin
         // Controls stay at their free-running values; registers clear below.
      end else if (mem_hold) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
         state_nx    = ST_HOLD;
         ret_nx      = eff_state;
      end else begin
         case (eff_state)
            ST_STALL: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               if (remain <= 2'd1) begin
                  state_nx  = ST_RUN;
                  remain_nx = 2'd0;
               end else begin
                  state_nx  = ST_STALL;
                  remain_nx = remain - 2'd1;
               end
            end
            default: begin
               state_nx = ST_RUN;
               if (hz_lb || hz_one) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  if (hz_lb) begin
                     state_nx  = ST_STALL;
                     remain_nx = 2'd1;
                  end
               end else begin
                  if_id_flush = if_id_is_branch && branch_taken;
               end
            end
         endcase
      end
   end

   // Sequencer registers; reset abandons any stall or hold in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         ret_state <= ST_RUN;
         remain    <= 2'd0;
      end else begin
         state     <= state_nx;
         ret_state <= ret_nx;
         remain    <= remain_nx;
      end
   end

   // Event counters, wrapping naturally; nothing counts while memory holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else if (!mem_hold) begin
         stall_cycles <= stall_cycles + CNT_W'(id_ex_bubble);
         flush_events <= flush_events + CNT_W'(if_id_flush);
      end
   end

endmodule
